// File: rtl/shift_serializer.sv
// Parallel-to-serial front end: accepts WIDTH-bit words over valid/ready and
// emits them one bit per clock with a matching enable strobe and frame marker.
module shift_serializer #(
  parameter int WIDTH     = 8,
  parameter int LSB_FIRST = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             serial_out,
  output logic             serial_en,
  output logic             frame_start,
  output logic             busy,
  output logic             state_dbg
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] sreg, sreg_nx;
  logic [WIDTH-1:0] hold, hold_nx;
  logic             hold_full, hold_full_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic [WIDTH-1:0] shifted;
  logic             accept;

  // Handshake: a word transfers on a rising edge where in_valid && in_ready;
  // in_ready depends only on registered state and reset, never on in_valid.
  assign in_ready = !hold_full && !reset;
  assign accept   = in_valid && in_ready;

  // Zero fill means sreg empties itself by the time the FSM returns to IDLE.
  assign shifted = (LSB_FIRST != 0) ? (sreg >> 1) : (sreg << 1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      sreg      <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      cnt       <= '0;
    end else begin
      state     <= state_nx;
      sreg      <= sreg_nx;
      hold      <= hold_nx;
      hold_full <= hold_full_nx;
      cnt       <= cnt_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    sreg_nx      = sreg;
    hold_nx      = hold;
    hold_full_nx = hold_full;
    cnt_nx       = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          sreg_nx  = in_data;
          cnt_nx   = '0;
          state_nx = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt != LAST) begin
          sreg_nx = shifted;
          cnt_nx  = cnt + CW'(1);
          if (accept) begin
            hold_nx      = in_data;
            hold_full_nx = 1'b1;
          end
        end else begin
          // Last bit: the held word wins; in_ready is low whenever hold_full is set.
          cnt_nx = '0;
          if (hold_full) begin
            sreg_nx      = hold;
            hold_full_nx = 1'b0;
          end else if (accept) begin
            sreg_nx = in_data;
          end else begin
            sreg_nx  = shifted;
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign serial_out  = (LSB_FIRST != 0) ? sreg[0] : sreg[WIDTH-1];
  assign serial_en   = (state == SHIFT);
  assign frame_start = serial_en && (cnt == '0);
  assign busy        = (state == SHIFT) || hold_full;
  assign state_dbg   = state;

endmodule
